cnn_tile_streamer: RTL and testbench

Stream-side companion to the 4x4 cellular-network tile. It accepts a byte stream of 16 input pixels (U) and 16 bias values (I), and presents them to the tile as stable parallel vectors. It then lets the tile iterate for a fixed number of 16-cycle sweeps, snapshots the 16 parallel 9-bit state outputs (Y1_out..Y16_out), and serialises them onto a valid/ready output stream. It is the write-in and read-out end of the tile's parallel U/I/Y interface.

---
 rtl/cnn_tile_streamer.sv | 103 ++++++++++
 tb/tb_cnn_tile_streamer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/cnn_tile_streamer.sv
// cnn_tile_streamer: byte-stream loader for tile U/I vectors, sweep timer, Y snapshot serialiser (s_* in, u_flat/i_flat/y_flat tile side, m_* out, busy/done status)
module cnn_tile_streamer #(
  parameter int ITER_SWEEPS = 8,
  parameter int SETTLE = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [127:0] u_flat,
  output logic [127:0] i_flat,
  input  logic [143:0] y_flat,
  output logic [8:0]   m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         m_last,
  output logic         busy,
  output logic         done
);
  typedef enum logic [2:0] {LOAD_U, LOAD_I, COMMIT, RUN, CAPTURE, DRAIN} state_t;
  localparam logic [11:0] RUN_LAST = 12'(ITER_SWEEPS * 16 + SETTLE - 1);
  state_t state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [11:0] cnt_q, cnt_d;
  logic [127:0] u_stage_q, u_stage_d, i_stage_q, i_stage_d;
  logic [127:0] u_flat_q, u_flat_d, i_flat_q, i_flat_d;
  logic [143:0] snap_q, snap_d;
  logic s_xfer, m_xfer;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    u_stage_d = u_stage_q;
    i_stage_d = i_stage_q;
    u_flat_d = u_flat_q;
    i_flat_d = i_flat_q;
    snap_d = snap_q;
    s_ready = state_q == LOAD_U || state_q == LOAD_I;
    m_valid = state_q == DRAIN;
    m_last = m_valid && idx_q == 4'd15;
    busy = state_q != LOAD_U;
    s_xfer = s_valid && s_ready;
    m_xfer = m_valid && m_ready;
    done = m_xfer && m_last;
    m_data = snap_q[{4'd0, idx_q} * 8'd9 +: 9];
    unique case (state_q)
      LOAD_U: if (s_xfer) begin
        u_stage_d[{idx_q, 3'b000} +: 8] = s_data;
        idx_d = idx_q + 4'd1;
        state_d = idx_q == 4'd15 ? LOAD_I : LOAD_U;
      end
      LOAD_I: if (s_xfer) begin
        i_stage_d[{idx_q, 3'b000} +: 8] = s_data;
        idx_d = idx_q + 4'd1;
        state_d = idx_q == 4'd15 ? COMMIT : LOAD_I;
      end
      COMMIT: begin
        u_flat_d = u_stage_q;
        i_flat_d = i_stage_q;
        cnt_d = '0;
        state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_q + 12'd1;
        state_d = cnt_q == RUN_LAST ? CAPTURE : RUN;
      end
      CAPTURE: begin
        snap_d = y_flat;
        idx_d = '0;
        state_d = DRAIN;
      end
      DRAIN: if (m_xfer) begin
        idx_d = idx_q + 4'd1;
        state_d = m_last ? LOAD_U : DRAIN;
      end
      default: state_d = LOAD_U;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD_U;
      idx_q <= '0;
      cnt_q <= '0;
      u_stage_q <= '0;
      i_stage_q <= '0;
      u_flat_q <= '0;
      i_flat_q <= '0;
      snap_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      u_stage_q <= u_stage_d;
      i_stage_q <= i_stage_d;
      u_flat_q <= u_flat_d;
      i_flat_q <= i_flat_d;
      snap_q <= snap_d;
    end
  end
  assign u_flat = u_flat_q;
  assign i_flat = i_flat_q;
endmodule

// File: tb/tb_cnn_tile_streamer.sv
// tb_cnn_tile_streamer: randomized bench for cnn_tile_streamer against a job-timeline model
module tb_cnn_tile_streamer;
  localparam int N = 18;
  logic clk = 0;
  logic rst_n = 0;
  logic [7:0] s_data;
  logic s_valid, s_ready;
  logic [127:0] u_flat, i_flat;
  logic [143:0] y_flat;
  logic [8:0] m_data;
  logic m_valid, m_ready, m_last, busy, done;
  int checks = 0, failures = 0, rdy_pct = 100;
  cnn_tile_streamer #(.ITER_SWEEPS(1), .SETTLE(2)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .u_flat(u_flat), .i_flat(i_flat), .y_flat(y_flat), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [143:0] rnd144();
    return 144'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
  endfunction
  logic [7:0] stage [32];
  int nb = 0, cyc = 0, t_last = 0, nout = 0, done_seen = 0;
  bit in_flight = 0;
  logic [127:0] mu = '0, mi = '0;
  logic [143:0] words = '0;
  logic [8:0] got [$];
  always @(negedge clk) begin : cmp
    int k;
    bit ev;
    if (!rst_n) begin
      nb = 0; in_flight = 0; nout = 0; mu = '0; mi = '0; words = '0;
    end else begin
      cyc++;
      k = cyc - t_last;
      ev = in_flight && k >= N + 3;
      check("s_ready", 144'(s_ready), 144'(!in_flight));
      check("busy", 144'(busy), 144'(in_flight || nb >= 16));
      check("m_valid", 144'(m_valid), 144'(ev));
      check("done", 144'(done), 144'(ev && m_ready && nout == 15));
      check("u_flat", 144'(u_flat), 144'(mu));
      check("i_flat", 144'(i_flat), 144'(mi));
      if (ev) begin
        check("m_data", 144'(m_data), 144'(words[nout*9 +: 9]));
        check("m_last", 144'(m_last), 144'(nout == 15));
      end
      if (done) done_seen++;
      if (!in_flight) begin
        if (s_valid) begin
          stage[nb] = s_data;
          nb++;
          if (nb == 32) begin in_flight = 1; t_last = cyc; end
        end
      end else if (k == 1) begin
        for (int i = 0; i < 16; i++) begin
          mu[i*8 +: 8] = stage[i];
          mi[i*8 +: 8] = stage[16+i];
        end
      end else if (k == N + 2) words = y_flat;
      else if (ev && m_ready) begin
        got.push_back(words[nout*9 +: 9]);
        nout++;
        if (nout == 16) begin in_flight = 0; nb = 0; nout = 0; end
      end
    end
  end
  initial forever begin
    @(posedge clk);
    #1;
    m_ready = $urandom_range(99) < rdy_pct;
  end
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic tick();
    @(posedge clk);
    #1;
    y_flat = rnd144();
  endtask
  task automatic send(input logic [7:0] b [32], input int n, input int gap);
    int i, g;
    i = 0;
    g = 0;
    while (i < n && g < 2000) begin
      s_valid = $urandom_range(99) >= gap;
      s_data = s_valid ? b[i] : 8'($urandom());
      @(negedge clk);
      if (s_valid && s_ready) i++;
      tick();
      g++;
    end
    s_valid = 0;
    check("send_bound", 144'(i), 144'(n));
  endtask
  task automatic wait_drain();
    int g;
    g = 0;
    while ((in_flight || nb != 0) && g < 3000) begin
      tick();
      g++;
    end
    check("drain_bound", 144'(in_flight), 144'(0));
  endtask
  initial begin
    logic [7:0] b [32];
    logic [143:0] yp;
    int d0;
    s_valid = 0;
    s_data = 0;
    y_flat = 0;
    m_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_s_ready", 144'(s_ready), 144'(1));
    check("rst_busy", 144'(busy), 144'(0));
    check("rst_m_valid", 144'(m_valid), 144'(0));
    check("rst_m_last", 144'(m_last), 144'(0));
    check("rst_done", 144'(done), 144'(0));
    check("rst_m_data", 144'(m_data), 144'(0));
    check("rst_u_flat", 144'(u_flat), 144'(0));
    tick();
    rst_n = 1;
    for (int i = 0; i < 16; i++) begin b[i] = 8'(i + 1); b[16+i] = 8'hFF; end
    got.delete();
    send(b, 32, 0);
    @(negedge clk);
    check("s_ready_drop", 144'(s_ready), 144'(0));
    check("i_flat_pre_commit", 144'(i_flat), 144'(0));
    tick();
    @(negedge clk);
    check("u_flat_pattern", 144'(u_flat), 144'(128'h100F0E0D0C0B0A090807060504030201));
    check("i_flat_pattern", 144'(i_flat), 144'({16{8'hFF}}));
    repeat (18) tick();
    for (int i = 0; i < 16; i++) yp[i*9 +: 9] = 9'(i - 7);
    y_flat = yp;
    tick();
    wait_drain();
    check("dir_count", 144'(got.size()), 144'(16));
    check("dir_first", 144'(got[0]), 144'(9'h1F9));
    check("dir_mid", 144'(got[7]), 144'(9'h000));
    check("dir_last", 144'(got[15]), 144'(9'h008));
    for (int i = 0; i < 32; i++) b[i] = 8'($urandom());
    send(b, 32, 0);
    for (int i = 0; i < 32; i++) b[i] = 8'($urandom());
    send(b, 20, 30);
    rst_n = 0;
    @(negedge clk);
    check("mid_rst_s_ready", 144'(s_ready), 144'(1));
    check("mid_rst_busy", 144'(busy), 144'(0));
    check("mid_rst_u_flat", 144'(u_flat), 144'(0));
    check("mid_rst_i_flat", 144'(i_flat), 144'(0));
    check("mid_rst_m_valid", 144'(m_valid), 144'(0));
    tick();
    rst_n = 1;
    got.delete();
    d0 = done_seen;
    rdy_pct = 50;
    for (int i = 0; i < 32; i++) b[i] = 8'($urandom());
    send(b, 32, 40);
    repeat (19) tick();
    yp = rnd144();
    yp[8:0] = 9'h0FF;
    yp[17:9] = 9'h100;
    y_flat = yp;
    tick();
    wait_drain();
    check("bp_count", 144'(got.size()), 144'(16));
    check("bp_word0", 144'(got[0]), 144'(9'h0FF));
    check("bp_word1", 144'(got[1]), 144'(9'h100));
    check("bp_done_once", 144'(done_seen - d0), 144'(1));
    got.delete();
    rdy_pct = 60;
    for (int i = 0; i < 32; i++) b[i] = 8'($urandom());
    send(b, 32, 0);
    for (int i = 0; i < 32; i++) b[i] = 8'($urandom());
    send(b, 32, 20);
    wait_drain();
    check("b2b_count", 144'(got.size()), 144'(32));
    for (int j = 0; j < 6; j++) begin
      rdy_pct = $urandom_range(30, 100);
      for (int i = 0; i < 32; i++) b[i] = 8'($urandom());
      send(b, 32, $urandom_range(0, 60));
      if (j % 2 == 1) wait_drain();
    end
    wait_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
